// File: rtl/mont_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_pkg
// Description : Shared width defaults and FSM state encoding for the
//               Montgomery multiplier and the long-division conversion stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_mul_pkg;

    localparam int unsigned C_DATA_W = 32;
    localparam int unsigned C_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } mm_state_t;

endpackage
`default_nettype wire

// File: rtl/mont_mul_step.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_step
// Description : One radix-2 Montgomery iteration: T' = (T + a_i*B [+ N]) / 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mul_step
    import mont_mul_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic [DATA_W+1:0] i_t,
    input  logic              i_a_bit,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_n,
    output logic [DATA_W+1:0] o_t
);

    logic [DATA_W+1:0] w_add_b;
    logic [DATA_W+1:0] w_add_n;

    // With T < 2N and B < N the running sum stays below 4N, so two guard bits suffice.
    always_comb begin
        w_add_b = i_t + (i_a_bit ? {2'b00, i_b} : '0);
        w_add_n = w_add_b + (w_add_b[0] ? {2'b00, i_n} : '0);
        o_t     = w_add_n >> 1;
    end

endmodule
`default_nettype wire

// File: rtl/mont_mul.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul
// Description : Bit-serial radix-2 Montgomery multiplier, A*B*2^-len mod N.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mul
    import mont_mul_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int LEN_W  = C_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mm_start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] modulus,
    output logic              mm_end,
    output logic [DATA_W-1:0] mm_out
);

    mm_state_t         r_state;
    mm_state_t         w_next_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_n;
    logic [DATA_W+1:0] r_t;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_out;
    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W+1:0] w_t_step;
    logic [DATA_W+1:0] w_t_sub;

    // More iterations than operand bits would only shift zeros through A.
    always_comb begin
        w_len_eff = len;
        if (32'(len) > 32'(DATA_W)) begin
            w_len_eff = LEN_W'(DATA_W);
        end
    end

    mont_mul_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_t     (r_t),
        .i_a_bit (r_a[0]),
        .i_b     (r_b),
        .i_n     (r_n),
        .o_t     (w_t_step)
    );

    always_comb begin
        w_t_sub = r_t;
        if (r_t >= {2'b00, r_n}) begin
            w_t_sub = r_t - {2'b00, r_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (mm_start) begin
                    w_next_state = (w_len_eff == '0) ? SUB : CALC;
                end
            end
            CALC: begin
                if (r_cnt == LEN_W'(1)) begin
                    w_next_state = SUB;
                end
            end
            SUB:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_n   <= '0;
            r_t   <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mm_start) begin
                        r_a   <= a_in;
                        r_b   <= b_in;
                        r_n   <= modulus;
                        r_t   <= '0;
                        r_cnt <= w_len_eff;
                    end
                end
                CALC: begin
                    r_t   <= w_t_step;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt - LEN_W'(1);
                end
                SUB: begin
                    // A zero modulus has no residue class; report 0 rather than raw T.
                    r_out <= (r_n == '0) ? '0 : w_t_sub[DATA_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_end = (r_state == DONE);
    assign mm_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mont_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_mont_mul
// Description : Scoreboard bench for mont_mul against a modular-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_mul;

    logic        clk;
    logic        rst;
    logic        mm_start;
    logic [7:0]  len;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] modulus;
    logic        mm_end;
    logic [31:0] mm_out;

    typedef struct {
        logic [31:0] res;
        int unsigned edge_no;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned edge_cnt = 0;

    mont_mul #(
        .DATA_W (32),
        .LEN_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mm_start (mm_start),
        .len      (len),
        .a_in     (a_in),
        .b_in     (b_in),
        .modulus  (modulus),
        .mm_end   (mm_end),
        .mm_out   (mm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // A*B*R^-1 mod N via (A*B mod N) * (2^-1 mod N)^len.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n, input int le);
        longint unsigned p, inv2, rinv, nn;
        if (n == 32'd0 || le == 0) return 32'd0;
        nn   = 64'(n);
        p    = (64'(a) * 64'(b)) % nn;
        inv2 = (nn + 64'd1) / 64'd2;
        rinv = 64'd1 % nn;
        for (int i = 0; i < le; i++) rinv = (rinv * inv2) % nn;
        return 32'((p * rinv) % nn);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every mm_end must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mm_end === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_end: got mm_end=1 at edge %0d expected no pulse", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mm_out", mm_out, e.res);
                check("end_edge", edge_cnt, e.edge_no);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                         input logic [7:0] l, input bit poke);
        int le;
        logic [31:0] r;
        le = (l > 8'd32) ? 32 : int'(l);
        r  = model(a, b, n, le);
        @(negedge clk);
        a_in = a; b_in = b; modulus = n; len = l; mm_start = 1'b1;
        sb.push_back('{r, edge_cnt + 32'(le) + 32'd2});
        @(negedge clk);
        mm_start = 1'b0;
        a_in = $urandom; b_in = $urandom; modulus = $urandom; len = 8'($urandom);
        if (poke) begin
            @(negedge clk);
            mm_start = 1'b1;
            @(negedge clk);
            mm_start = 1'b0;
        end
        repeat (le + 3) @(negedge clk);
        check("hold", mm_out, r);
    endtask

    initial begin
        rst = 1'b1; mm_start = 1'b0; len = '0; a_in = '0; b_in = '0; modulus = '0;
        repeat (3) @(negedge clk);
        check("reset_out", mm_out, 32'd0);
        check("reset_end", 32'(mm_end), 32'd0);
        rst = 1'b0;

        // Reset and start together: nothing may start.
        @(negedge clk);
        rst = 1'b1; mm_start = 1'b1; a_in = 32'd6; b_in = 32'd6; modulus = 32'd11; len = 8'd4;
        @(negedge clk);
        rst = 1'b0; mm_start = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_start_out", mm_out, 32'd0);

        do_op(32'd6, 32'd6, 32'd11, 8'd4, 1'b0);

        // Reset during cycle 3 of an operation aborts it.
        @(negedge clk);
        a_in = 32'd6; b_in = 32'd6; modulus = 32'd11; len = 8'd4; mm_start = 1'b1;
        @(negedge clk);
        mm_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_out", mm_out, 32'd0);

        do_op(32'd6, 32'd6, 32'd11, 8'd4, 1'b0);
        do_op(32'd10, 32'd1, 32'd13, 8'd4, 1'b0);
        do_op(32'd6, 32'd5, 32'd7, 8'd3, 1'b1);
        do_op(32'd5, 32'h1234_5678, 32'hFFFF_FFFB, 8'd32, 1'b0);
        do_op(32'd6, 32'd6, 32'd0, 8'd4, 1'b0);
        do_op(32'd6, 32'd6, 32'd11, 8'd0, 1'b0);
        do_op(32'd5, 32'h1234_5678, 32'hFFFF_FFFB, 8'd200, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0]  l;
            logic [31:0] mask, n, a, b;
            int le;
            l    = 8'($urandom_range(0, 40));
            le   = (l > 8'd32) ? 32 : int'(l);
            mask = (le >= 32) ? 32'hFFFF_FFFF : ((32'd1 << le) - 32'd1);
            n    = ($urandom & mask) | 32'd1;
            if ($urandom_range(0, 9) == 0) n = 32'd0;
            a    = (n == 32'd0) ? $urandom : ($urandom % n);
            b    = (n == 32'd0) ? $urandom : ($urandom % n);
            do_op(a, b, n, l, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("pending", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mont_mul.md
MONT_MUL -- requirements
Module: mont_mul

Interface
REQ-001 Parameter DATA_W, default 32, operand/modulus width.
REQ-002 Parameter LEN_W, default 8, width of len (log2 R).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mm_start  input  1  start pulse; sampled only in IDLE.
REQ-006 len  input  LEN_W  log2(R); R = 2^len.
REQ-007 a_in  input  DATA_W  Montgomery-form operand A, from the long-division domain-conversion stage.
REQ-008 b_in  input  DATA_W  Montgomery-form operand B.
REQ-009 modulus  input  DATA_W  modulus N; odd, A,B < N, N < 2^len.
REQ-010 mm_end  output  1  one-cycle done pulse.
REQ-011 mm_out  output  DATA_W  result A*B*R^-1 mod N.

Function
REQ-012 Block SHALL compute A*B*R^-1 mod N by radix-2 bit-serial Montgomery multiplication, one bit of A per cycle, LSB first.
REQ-013 FSM states SHALL be IDLE, CALC, SUB, DONE.
REQ-014 IDLE: on mm_start=1, latch a_in, b_in, modulus, len; clear accumulator T; go to CALC (len>0) or SUB (len=0).
REQ-015 CALC iteration i: T = T + a_i*B; if T odd, T = T + N; T = T >> 1; after len iterations go to SUB.
REQ-016 Accumulator SHALL be DATA_W+2 bits; no intermediate overflow for any legal input.
REQ-017 SUB: if T >= N, T = T - N; register result to mm_out; go to DONE.
REQ-018 DONE: mm_end=1 for exactly one cycle; return to IDLE.
REQ-019 Latency: mm_start sampled at edge 0 -> mm_end high in cycle len+2; mm_out valid the same cycle.
REQ-020 mm_out SHALL hold its value until the next SUB completes.
REQ-021 mm_start SHALL be ignored in CALC, SUB, DONE; no queuing.
REQ-022 len > DATA_W SHALL be clamped to DATA_W iterations.
REQ-023 len = 0 SHALL produce mm_out = 0 with mm_end in cycle 2.
REQ-024 modulus = 0 SHALL produce mm_out = 0 with normal latency; no hang.
REQ-025 Input changes after the start cycle SHALL not affect the running operation.

Reset
REQ-026 rst=1 SHALL force IDLE, T=0, mm_out=0, mm_end=0 on the next edge.
REQ-027 rst asserted mid-operation SHALL abort; no mm_end pulse for the aborted operation.
REQ-028 rst and mm_start high together: rst wins; no operation starts.

Structure
REQ-029 Shared package SHALL hold DATA_W, LEN_W defaults and the FSM state enum, shared with the long-division stage.
REQ-030 One sub-module mont_mul_step SHALL implement one combinational CALC iteration (T, a_i, B, N -> next T).
REQ-031 Iteration counter SHALL be LEN_W bits, counting down from the latched len.

Verification
REQ-032 N=11, len=4, A=6, B=6, start pulse -> mm_end in cycle 6, mm_out=5.
REQ-033 N=13, len=4, A=10, B=1 -> mm_out=12 (conversion out of Montgomery form).
REQ-034 N=7, len=3, A=6, B=5 -> mm_out=2; second mm_start during CALC ignored, exactly one mm_end.
REQ-035 N=0xFFFFFFFB, len=32, A=5, B=0x12345678 -> mm_out=0x12345678, mm_end in cycle 34.
REQ-036 modulus=0, len=4 -> mm_out=0, mm_end in cycle 6; then len=0, N=11 -> mm_out=0, mm_end in cycle 2.
REQ-037 rst pulse in cycle 3 of N=11, len=4 operation -> mm_out=0, no mm_end; next operation completes correctly.
